// File: rtl/dirty_mem_dumper_pkg.sv
// dirty_mem_dumper_pkg: shared sizing defaults and FSM state encoding
// for the dirty-word memory dumper.
package dirty_mem_dumper_pkg;

  localparam int N_ELEMENTS_DEF = 128;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int ADDRWIDTH_DEF  = $clog2(N_ELEMENTS_DEF);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SCAN = 3'd1,
    ST_READ = 3'd2,
    ST_SEND = 3'd3,
    ST_DONE = 3'd4
  } state_t;

endpackage

// File: rtl/dirty_bitmap.sv
// dirty_bitmap: one dirty bit per data-memory word, with a set port,
// a clear port (set wins on collision) and a combinational read port.
module dirty_bitmap
  import dirty_mem_dumper_pkg::*;
#(
  parameter int N_ELEMENTS = N_ELEMENTS_DEF,
  parameter int ADDRWIDTH  = $clog2(N_ELEMENTS)
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_set,
  input  logic [ADDRWIDTH-1:0] i_set_addr,
  input  logic                 i_clr,
  input  logic [ADDRWIDTH-1:0] i_clr_addr,
  input  logic [ADDRWIDTH-1:0] i_rd_addr,
  output logic                 o_rd_bit
);

  logic [N_ELEMENTS-1:0] r_bits;
  logic [N_ELEMENTS-1:0] w_bits_nxt;

  // next bitmap: clear first, then set so a same-cycle store keeps the bit
  always_comb begin
    w_bits_nxt = r_bits;
    if (i_clr) begin
      w_bits_nxt[i_clr_addr] = 1'b0;
    end
    if (i_set) begin
      w_bits_nxt[i_set_addr] = 1'b1;
    end
  end

  // bitmap register, cleared only by reset
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_bits <= '0;
    end else begin
      r_bits <= w_bits_nxt;
    end
  end

  assign o_rd_bit = r_bits[i_rd_addr];

endmodule

// File: rtl/dirty_mem_dumper.sv
// dirty_mem_dumper: scans the dirty bitmap and streams address/data of
// every dirty word; DUMP_CLEAR_ON_SEND_EN makes a handshake clear the bit.
module dirty_mem_dumper
  import dirty_mem_dumper_pkg::*;
#(
  parameter int N_ELEMENTS = N_ELEMENTS_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  localparam int ADDRWIDTH = $clog2(N_ELEMENTS)
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_mem_write,
  input  logic [ADDRWIDTH-1:0]  i_wr_addr,
  input  logic                  i_start,
  output logic                  o_rd_en,
  output logic [ADDRWIDTH-1:0]  o_rd_addr,
  input  logic [DATA_WIDTH-1:0] i_rd_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [ADDRWIDTH-1:0]  o_addr,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam logic [ADDRWIDTH-1:0] LAST = ADDRWIDTH'(N_ELEMENTS - 1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDRWIDTH-1:0]  r_index;
  logic [ADDRWIDTH-1:0]  w_index_nxt;
  logic [ADDRWIDTH-1:0]  r_addr;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  w_capture;
  logic                  w_dirty;
  logic                  w_clr;

`ifdef DUMP_CLEAR_ON_SEND_EN
  assign w_clr = (r_state == ST_SEND) && i_ready;
`else
  assign w_clr = 1'b0;
`endif

  dirty_bitmap #(
    .N_ELEMENTS (N_ELEMENTS),
    .ADDRWIDTH  (ADDRWIDTH)
  ) u_bitmap (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_set      (i_mem_write),
    .i_set_addr (i_wr_addr),
    .i_clr      (w_clr),
    .i_clr_addr (r_index),
    .i_rd_addr  (r_index),
    .o_rd_bit   (w_dirty)
  );

  // state and scan index registers
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= ST_IDLE;
      r_index <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_index <= w_index_nxt;
    end
  end

  // next-state, index advance and Moore outputs
  always_comb begin
    w_state_nxt = r_state;
    w_index_nxt = r_index;
    w_capture   = 1'b0;
    o_rd_en     = 1'b0;
    o_valid     = 1'b0;
    o_done      = 1'b0;
    o_busy      = 1'b1;
    unique case (r_state)
      ST_IDLE: begin
        o_busy = 1'b0;
        if (i_start) begin
          w_state_nxt = ST_SCAN;
          w_index_nxt = '0;
        end
      end
      ST_SCAN: begin
        if (w_dirty) begin
          w_state_nxt = ST_READ;
        end else if (r_index == LAST) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_index_nxt = r_index + 1'b1;
        end
      end
      ST_READ: begin
        o_rd_en     = 1'b1;
        w_capture   = 1'b1;
        w_state_nxt = ST_SEND;
      end
      ST_SEND: begin
        o_valid = 1'b1;
        if (i_ready) begin
          if (r_index == LAST) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt = ST_SCAN;
            w_index_nxt = r_index + 1'b1;
          end
        end
      end
      ST_DONE: begin
        o_done      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // dump word capture at the end of the read cycle
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_addr <= '0;
      r_data <= '0;
    end else if (w_capture) begin
      r_addr <= r_index;
      r_data <= i_rd_data;
    end
  end

  assign o_rd_addr = r_index;
  assign o_addr    = r_addr;
  assign o_data    = r_data;

endmodule

// File: tb/tb_dirty_mem_dumper.sv
// tb_dirty_mem_dumper: directed bench with a queue-based reference of the
// dirty set and the expected dump order, checked every cycle.
module tb_dirty_mem_dumper;

  localparam int N  = 128;
  localparam int DW = 32;
  localparam int AW = 7;

  logic          i_clock = 1'b0;
  logic          i_reset = 1'b0;
  logic          i_mem_write = 1'b0;
  logic [AW-1:0] i_wr_addr = '0;
  logic          i_start = 1'b0;
  logic          o_rd_en;
  logic [AW-1:0] o_rd_addr;
  logic [DW-1:0] i_rd_data;
  logic          o_valid;
  logic          i_ready = 1'b0;
  logic [AW-1:0] o_addr;
  logic [DW-1:0] o_data;
  logic          o_busy;
  logic          o_done;

  logic [DW-1:0] mem [N];
  logic [N-1:0]  m_bits;
  logic [AW-1:0] q[$];
  logic [AW-1:0] got[$];
  logic [DW-1:0] gotd[$];
  logic          m_busy;
  logic          prev_pend;
  logic [AW-1:0] prev_addr;
  logic [DW-1:0] prev_data;
  int            n_checks = 0;
  int            n_fail = 0;
  int            done_cnt = 0;

  dirty_mem_dumper dut (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .i_mem_write (i_mem_write),
    .i_wr_addr   (i_wr_addr),
    .i_start     (i_start),
    .o_rd_en     (o_rd_en),
    .o_rd_addr   (o_rd_addr),
    .i_rd_data   (i_rd_data),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_addr      (o_addr),
    .o_data      (o_data),
    .o_busy      (o_busy),
    .o_done      (o_done)
  );

  always #5 i_clock = ~i_clock;

  assign i_rd_data = o_rd_en ? mem[o_rd_addr] : 32'hDEAD_BEEF;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge i_clock);
    #1;
  endtask

  task automatic wr(input int a);
    i_mem_write = 1'b1;
    i_wr_addr   = AW'(a);
    cyc();
    i_mem_write = 1'b0;
  endtask

  task automatic start();
    i_start = 1'b1;
    cyc();
    i_start = 1'b0;
  endtask

  task automatic reset_dut();
    i_reset = 1'b0;
    cyc();
    cyc();
    i_reset = 1'b1;
    cyc();
  endtask

  task automatic wait_done(input int limit);
    int n = 0;
    int d0 = done_cnt;
    while (done_cnt == d0 && n < limit) begin
      cyc();
      n++;
    end
    check("done_timeout", 64'(n < limit), 64'd1);
    check("done_once", 64'(done_cnt - d0), 64'd1);
    cyc();
  endtask

  task automatic wait_valid(input int limit);
    int n = 0;
    while (!o_valid && n < limit) begin
      cyc();
      n++;
    end
    check("valid_timeout", 64'(n < limit), 64'd1);
  endtask

  // reference: dirty set, expected dump queue, handshake log
  always @(negedge i_clock) begin
    if (!i_reset) begin
      check("rst_valid", 64'(o_valid), 64'd0);
      check("rst_busy", 64'(o_busy), 64'd0);
      check("rst_done", 64'(o_done), 64'd0);
      check("rst_rd_en", 64'(o_rd_en), 64'd0);
      check("rst_addr", 64'(o_addr), 64'd0);
      check("rst_data", 64'(o_data), 64'd0);
      m_bits    = '0;
      q.delete();
      m_busy    = 1'b0;
      prev_pend = 1'b0;
    end else begin
      check("busy", 64'(o_busy), 64'(m_busy));
      if (o_rd_en) begin
        if (q.size() == 0) check("rd_unexpected", 64'd1, 64'd0);
        else check("rd_addr", 64'(o_rd_addr), 64'(q[0]));
      end
      if (o_valid) begin
        if (q.size() == 0) begin
          check("valid_unexpected", 64'd1, 64'd0);
        end else begin
          check("dump_addr", 64'(o_addr), 64'(q[0]));
          check("dump_data", 64'(o_data), 64'(mem[q[0]]));
        end
      end
      if (prev_pend) begin
        check("hold_valid", 64'(o_valid), 64'd1);
        check("hold_addr", 64'(o_addr), 64'(prev_addr));
        check("hold_data", 64'(o_data), 64'(prev_data));
      end
      if (o_done) begin
        check("done_q_empty", 64'(q.size()), 64'd0);
        done_cnt++;
      end
      if (o_valid && i_ready) begin
        got.push_back(o_addr);
        gotd.push_back(o_data);
        if (q.size() != 0) begin
`ifdef DUMP_CLEAR_ON_SEND_EN
          m_bits[q[0]] = 1'b0;
`endif
          void'(q.pop_front());
        end
      end
      if (i_mem_write) m_bits[i_wr_addr] = 1'b1;
      if (i_start && !m_busy) begin
        m_busy = 1'b1;
        q.delete();
        for (int k = 0; k < N; k++) begin
          if (m_bits[k]) q.push_back(AW'(k));
        end
      end
      if (o_done) m_busy = 1'b0;
      prev_pend = o_valid && !i_ready;
      prev_addr = o_addr;
      prev_data = o_data;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    for (int i = 0; i < N; i++) mem[i] = 32'hA5A5_0000 + 32'(i * 7);
    m_bits = '0;
    m_busy = 1'b0;
    prev_pend = 1'b0;
    cyc();
    cyc();
    i_reset = 1'b1;
    cyc();

    // three dirty words, consumer always ready
    got.delete(); gotd.delete();
    wr(3); wr(10); wr(127);
    i_ready = 1'b1;
    start();
    wait_done(400);
    check("t1_count", 64'(got.size()), 64'd3);
    if (got.size() == 3) begin
      check("t1_a0", 64'(got[0]), 64'd3);
      check("t1_a1", 64'(got[1]), 64'd10);
      check("t1_a2", 64'(got[2]), 64'd127);
      check("t1_d0", 64'(gotd[0]), 64'hA5A5_0015);
      check("t1_d2", 64'(gotd[2]), 64'hA5A5_0379);
    end

    // backpressure: word 5 held for 20 cycles
    reset_dut();
    got.delete(); gotd.delete();
    i_ready = 1'b0;
    wr(5);
    start();
    wait_valid(50);
    for (int i = 0; i < 20; i++) begin
      check("bp_valid", 64'(o_valid), 64'd1);
      check("bp_addr", 64'(o_addr), 64'd5);
      cyc();
    end
    check("bp_none_yet", 64'(got.size()), 64'd0);
    i_ready = 1'b1;
    cyc();
    wait_done(400);
    check("bp_count", 64'(got.size()), 64'd1);

    // empty bitmap: done after 129 cycles, nothing emitted
    reset_dut();
    got.delete(); gotd.delete();
    i_start = 1'b1;
    cyc();
    i_start = 1'b0;
    cnt = 1;
    while (!o_done && cnt < 300) begin
      cyc();
      cnt++;
    end
    check("empty_latency", 64'(cnt), 64'd129);
    cyc();
    check("empty_count", 64'(got.size()), 64'd0);

    // reset while sending word 40
    reset_dut();
    got.delete(); gotd.delete();
    i_ready = 1'b0;
    wr(40);
    start();
    wait_valid(100);
    check("rs_addr", 64'(o_addr), 64'd40);
    cnt = done_cnt;
    #2 i_reset = 1'b0;
    #1;
    check("rs_valid_now", 64'(o_valid), 64'd0);
    check("rs_busy_now", 64'(o_busy), 64'd0);
    cyc();
    i_reset = 1'b1;
    cyc();
    check("rs_no_done", 64'(done_cnt), 64'(cnt));
    i_ready = 1'b1;
    wr(12);
    start();
    wait_done(400);
    check("rs_count", 64'(got.size()), 64'd1);
    if (got.size() == 1) check("rs_a0", 64'(got[0]), 64'd12);

`ifdef DUMP_CLEAR_ON_SEND_EN
    // store to 7 in its own handshake cycle keeps it dirty
    reset_dut();
    got.delete(); gotd.delete();
    i_ready = 1'b0;
    wr(7); wr(20);
    start();
    wait_valid(50);
    check("cl_addr", 64'(o_addr), 64'd7);
    i_ready = 1'b1;
    i_mem_write = 1'b1;
    i_wr_addr = 7'd7;
    cyc();
    i_mem_write = 1'b0;
    wait_done(400);
    check("cl_count1", 64'(got.size()), 64'd2);
    got.delete(); gotd.delete();
    start();
    wait_done(400);
    check("cl_count2", 64'(got.size()), 64'd1);
    if (got.size() == 1) check("cl_again7", 64'(got[0]), 64'd7);
`else
    // snapshot mode: two dumps emit the same words
    reset_dut();
    i_ready = 1'b1;
    wr(2); wr(9);
    for (int p = 0; p < 2; p++) begin
      got.delete(); gotd.delete();
      start();
      wait_done(400);
      check("snap_count", 64'(got.size()), 64'd2);
      if (got.size() == 2) begin
        check("snap_a0", 64'(got[0]), 64'd2);
        check("snap_a1", 64'(got[1]), 64'd9);
      end
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
